// File: rtl/present_inv_cipher.sv
// Iterative PRESENT-80 decryption engine: rolls the key schedule forward to K32,
// then unwinds the 31 rounds one per cycle with the inverse P-layer, inverse S-box and reverse schedule.
module present_inv_cipher #(
   parameter int unsigned BLOCK_BITS = 64,
   parameter int unsigned KEY_BITS   = 80,
   parameter int unsigned ROUNDS     = 31
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BLOCK_BITS-1:0] ct_in,
   input  logic [KEY_BITS-1:0]   key_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BLOCK_BITS-1:0] pt_out,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, KEYFWD, DECRYPT, DONE} fsm_t;

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

   fsm_t                  fsm_q, fsm_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [BLOCK_BITS-1:0] state_q, state_d;
   logic [KEY_BITS-1:0]   key_q, key_d;
   logic [KEY_BITS-1:0]   key_step, key_back;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
         4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
         4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
         4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
         4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
         4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
         4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Forward schedule step: rotate left by 61, S-box the top nibble, fold in the round counter.
   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r          = {k[18:0], k[79:19]};
      r[79:76]   = sbox(r[79:76]);
      r[19:15]   = r[19:15] ^ i;
      return r;
   endfunction

   // Exact inverse of key_fwd: undo the counter, undo the S-box, rotate right by 61.
   function automatic logic [79:0] key_rev(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r          = k;
      r[19:15]   = r[19:15] ^ i;
      r[79:76]   = sbox_inv(r[79:76]);
      return {r[60:0], r[79:61]};
   endfunction

   function automatic logic [63:0] inv_player(input logic [63:0] s);
      logic [63:0] r;
      r = '0;
      for (int unsigned i = 0; i < 63; i++) begin
         r[6'(i)] = s[6'((16 * i) % 63)];
      end
      r[63] = s[63];
      return r;
   endfunction

   function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
      logic [63:0] r;
      r = '0;
      for (int unsigned n = 0; n < 16; n++) begin
         r[6'(4 * n) +: 4] = sbox_inv(s[6'(4 * n) +: 4]);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         fsm_q   <= IDLE;
         cnt_q   <= '0;
         state_q <= '0;
         key_q   <= '0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      key_d     = key_q;
      key_step  = key_fwd(key_q, cnt_q);
      key_back  = key_rev(key_q, cnt_q);
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      pt_out    = state_q;

      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ct_in;
               key_d   = key_in;
               cnt_d   = 5'd1;
               fsm_d   = KEYFWD;
            end
         end
         KEYFWD: begin
            busy  = 1'b1;
            key_d = key_step;
            // Whitening with K32 happens on the last schedule step so DECRYPT starts at round 31.
            if (cnt_q == LAST_ROUND) begin
               state_d = state_q ^ key_step[79:16];
               fsm_d   = DECRYPT;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         DECRYPT: begin
            busy    = 1'b1;
            key_d   = key_back;
            state_d = inv_sbox_layer(inv_player(state_q)) ^ key_back[79:16];
            if (cnt_q == 5'd1) begin
               fsm_d = DONE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_present_inv_cipher.sv
// Self-checking bench for present_inv_cipher: transaction-level PRESENT model plus a per-cycle output checker.
module tb_present_inv_cipher;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] ct_in = '0;
   logic [79:0] key_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] pt_out;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   localparam int SBOX[16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
   localparam logic [79:0] KEY_F = 80'hFFFFFFFFFFFFFFFFFFFF;

   present_inv_cipher #(.BLOCK_BITS(64), .KEY_BITS(80), .ROUNDS(31)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ct_in(ct_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
      .pt_out(pt_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain PRESENT-80 arithmetic) ----------------
   function automatic logic [3:0] s_fwd(input logic [3:0] x);
      return 4'(SBOX[x]);
   endfunction

   function automatic logic [3:0] s_inv(input logic [3:0] y);
      for (int v = 0; v < 16; v++) begin
         if (4'(SBOX[v]) == y) return 4'(v);
      end
      return 4'h0;
   endfunction

   function automatic int pbit(input int b);
      return (b == 63) ? 63 : (b * 16) % 63;
   endfunction

   function automatic logic [63:0] round_key(input logic [79:0] key, input int r);
      logic [79:0] k;
      k = key;
      for (int i = 1; i < r; i++) begin
         k = (k << 61) | (k >> 19);
         k[79:76] = s_fwd(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(i);
      end
      return k[79:16];
   endfunction

   function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [79:0] key);
      logic [63:0] s, u, t;
      logic [5:0]  base;
      s = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ round_key(key, r);
         for (int n = 0; n < 16; n++) begin
            base = 6'(n * 4);
            u[base +: 4] = s_fwd(s[base +: 4]);
         end
         for (int b = 0; b < 64; b++) t[6'(pbit(b))] = u[6'(b)];
         s = t;
      end
      return s ^ round_key(key, 32);
   endfunction

   function automatic logic [63:0] ref_decrypt(input logic [63:0] ct, input logic [79:0] key);
      logic [63:0] s, u, t;
      logic [5:0]  base;
      s = ct ^ round_key(key, 32);
      for (int r = 31; r >= 1; r--) begin
         for (int b = 0; b < 64; b++) t[6'(b)] = s[6'(pbit(b))];
         for (int n = 0; n < 16; n++) begin
            base = 6'(n * 4);
            u[base +: 4] = s_inv(t[base +: 4]);
         end
         s = u ^ round_key(key, r);
      end
      return s;
   endfunction

   // ---------------- cycle checker: 0 idle, 1 busy, 2 done ----------------
   int          m_mode  = 0;
   int          m_age   = 0;
   bit          m_live  = 1'b0;
   bit          m_known = 1'b0;
   logic [63:0] m_res   = '0;
   logic [63:0] m_pt    = '0;

   initial begin
      forever begin
         @(posedge clk);
         if (!reset) begin
            m_mode  = 0;
            m_pt    = '0;
            m_known = 1'b1;
            m_live  = 1'b1;
         end else if (m_live) begin
            case (m_mode)
               0: if (in_valid) begin
                  m_mode  = 1;
                  m_age   = 0;
                  m_known = 1'b0;
                  m_res   = ref_decrypt(ct_in, key_in);
               end
               1: begin
                  m_age++;
                  if (m_age == 62) begin
                     m_mode = 2;
                     m_pt   = m_res;
                  end
               end
               default: if (out_ready) m_mode = 0;
            endcase
         end
         #1;
         if (m_live) begin
            chk1("out_valid", out_valid, m_mode == 2);
            chk1("in_ready", in_ready, m_mode == 0);
            chk1("busy", busy, m_mode == 1);
            if (m_mode == 2 || m_known) chk64("pt_out", pt_out, m_pt);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_ready();
      int w;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_ready: in_ready still %b after %0d cycles, expected 1", in_ready, w);
      end
   endtask

   task automatic wait_valid(input bit noise, output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         if (noise) begin
            in_valid  = 1'($urandom_range(0, 1));
            ct_in     = {$urandom, $urandom};
            key_in    = {16'($urandom), $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!out_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_valid: out_valid still %b after %0d cycles, expected 1", out_valid, n);
      end
   endtask

   task automatic run_job(input logic [63:0] ct, input logic [79:0] key, input int hold,
                          input bit noise, output logic [63:0] got, output int lat);
      wait_ready();
      ct_in    = ct;
      key_in   = key;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(noise, lat);
      repeat (hold) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            ct_in    = {$urandom, $urandom};
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      got       = pt_out;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic [63:0] got, rct, rpt;
   logic [79:0] rkey;
   int          lat;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Model pinned to the published PRESENT-80 vectors, and round-trip consistency.
      chk64("model_v1", ref_decrypt(64'h5579C1387B228445, '0), 64'h0);
      chk64("model_v2", ref_decrypt(64'hE72C46C0F5945049, KEY_F), 64'h0);
      chk64("model_v3", ref_decrypt(64'hA112FFC72F68417B, '0), 64'hFFFFFFFFFFFFFFFF);
      chk64("model_v4", ref_decrypt(64'h3333DCD3213210D2, KEY_F), 64'hFFFFFFFFFFFFFFFF);
      chk64("model_enc", ref_encrypt(64'h0, '0), 64'h5579C1387B228445);
      for (int i = 0; i < 3; i++) begin
         rpt  = {$urandom, $urandom};
         rkey = {16'($urandom), $urandom, $urandom};
         chk64("model_roundtrip", ref_decrypt(ref_encrypt(rpt, rkey), rkey), rpt);
      end

      run_job(64'h5579C1387B228445, '0, 2, 1'b0, got, lat);
      chk64("case1_pt", got, 64'h0);
      chk64("case1_latency", 64'(lat), 64'd62);
      run_job(64'hE72C46C0F5945049, KEY_F, 0, 1'b0, got, lat);
      chk64("case2_pt", got, 64'h0);
      run_job(64'hA112FFC72F68417B, '0, 1, 1'b0, got, lat);
      chk64("case3a_pt", got, 64'hFFFFFFFFFFFFFFFF);
      // Backpressure for 10 cycles and junk in_valid pulses during the job.
      run_job(64'h3333DCD3213210D2, KEY_F, 10, 1'b1, got, lat);
      chk64("case3b_pt", got, 64'hFFFFFFFFFFFFFFFF);

      // Reset in the middle of a job.
      wait_ready();
      ct_in    = 64'h5579C1387B228445;
      key_in   = '0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk64("rst_pt_out", pt_out, 64'h0);
      run_job(64'h5579C1387B228445, '0, 0, 1'b0, got, lat);
      chk64("case5_rerun_pt", got, 64'h0);
      chk64("case5_latency", 64'(lat), 64'd62);

      // Back-to-back jobs.
      wait_ready();
      ct_in    = 64'hA112FFC72F68417B;
      key_in   = '0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid(1'b0, lat);
      chk64("b2b_first_pt", pt_out, 64'hFFFFFFFFFFFFFFFF);
      out_ready = 1'b1;
      ct_in     = 64'hE72C46C0F5945049;
      key_in    = KEY_F;
      in_valid  = 1'b1;
      @(negedge clk);
      chk1("b2b_in_ready", in_ready, 1'b1);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      chk1("b2b_busy", busy, 1'b1);
      wait_valid(1'b0, lat);
      chk64("b2b_second_pt", pt_out, 64'h0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Randomised jobs with random backpressure and input noise.
      for (int j = 0; j < 25; j++) begin
         rct  = {$urandom, $urandom};
         rkey = {16'($urandom), $urandom, $urandom};
         run_job(rct, rkey, $urandom_range(0, 4), 1'b1, got, lat);
         chk64("rand_pt", got, ref_decrypt(rct, rkey));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
